// File: rtl/seg7_pkg.sv
// Shared widths, segment patterns, conversion FSM encoding and helpers for the
// seg7_scan_display block.
package seg7_pkg;

  localparam int unsigned NUM_W   = 15;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned DIGITS  = 5;
  localparam int unsigned BCD_W   = DIGITS * DIGIT_W;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned CNT_W   = 4;

  // Active-low segment patterns, bit order g..a
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_LOAD = 2'd2
  } conv_state_e;

  function automatic logic [6:0] seg7_decode(input logic [DIGIT_W-1:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift
  function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (b[k*DIGIT_W +: DIGIT_W] >= DIGIT_W'(5))
        r[k*DIGIT_W +: DIGIT_W] = b[k*DIGIT_W +: DIGIT_W] + DIGIT_W'(3);
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_scan_display_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one input bit per clock,
// busy from start until the result is presented with a one-cycle done pulse.
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [NUM_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  conv_state_e      state_q, state_d;
  logic [NUM_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [BCD_W-1:0] adj_c;
  logic [BCD_W+NUM_W-1:0] shift_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    adj_c   = bcd_add3(bcd_q);
    shift_c = {adj_c, bin_q} << 1;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CONV;
          bin_d   = bin;
          bcd_d   = '0;
          cnt_d   = CNT_W'(NUM_W - 1);
          busy_d  = 1'b1;
        end
      end
      ST_CONV: begin
        bcd_d = shift_c[BCD_W+NUM_W-1 -: BCD_W];
        bin_d = shift_c[NUM_W-1:0];
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = ST_LOAD;
          done_d  = 1'b1;
        end
      end
      ST_LOAD: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed 5-digit common-anode 7-segment driver fed by a 15-bit binary value.
// Define SEG7_LZ_BLANK_EN to enable leading-zero blanking.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned SCAN_HZ = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NUM_W-1:0] number,
  output logic [6:0]       seg,
  output logic             dp,
  output logic [DIGITS-1:0] an,
  output logic             busy
);

  localparam int unsigned DIV   = CLK_HZ / SCAN_HZ;
  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic              valid_q, valid_d;
  logic [NUM_W-1:0]  last_q, last_d;
  logic [BCD_W-1:0]  digit_q, digit_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [DIGITS-1:0] lz_blank;
  logic              start_c;
  logic              wrap_c;
  logic [DIGIT_W-1:0] digit_c;
  logic              conv_busy;
  logic              conv_done;
  logic [BCD_W-1:0]  conv_bcd;

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (start_c),
    .bin   (number),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      last_q  <= '0;
      digit_q <= '0;
      pre_q   <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_BLANK;
      an_q    <= '1;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
      digit_q <= digit_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  // Restart whenever the converter is idle and the shown value is stale
  always_comb begin
    start_c = !conv_busy && (!valid_q || (number != last_q));
    last_d  = start_c ? number : last_q;
    valid_d = valid_q | conv_done;
    digit_d = conv_done ? conv_bcd : digit_q;

    wrap_c = (pre_q == PRE_W'(DIV - 1));
    pre_d  = wrap_c ? '0 : pre_q + PRE_W'(1);
    idx_d  = idx_q;
    if (wrap_c)
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);

    digit_c = digit_q[idx_q*DIGIT_W +: DIGIT_W];
    an_d    = '1;
    seg_d   = SEG_BLANK;
    if (valid_q && !lz_blank[idx_q]) begin
      an_d  = ~(DIGITS'(1) << idx_q);
      seg_d = seg7_decode(digit_c);
    end
  end

`ifdef SEG7_LZ_BLANK_EN
  logic [DIGITS-1:0] lz_blank_q, lz_blank_d, lz_mask_c;

  // Digit k>0 is blank when it and every higher digit are zero
  always_comb begin
    lz_mask_c = '0;
    lz_mask_c[DIGITS-1] = (conv_bcd[BCD_W-1 -: DIGIT_W] == '0);
    for (int k = int'(DIGITS) - 2; k >= 1; k--)
      lz_mask_c[k] = lz_mask_c[k+1] && (conv_bcd[k*DIGIT_W +: DIGIT_W] == '0);
    lz_blank_d = conv_done ? lz_mask_c : lz_blank_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lz_blank_q <= '0;
    else        lz_blank_q <= lz_blank_d;
  end

  assign lz_blank = lz_blank_q;
`else
  assign lz_blank = '0;
`endif

  assign seg  = seg_q;
  assign an   = an_q;
  assign dp   = 1'b1;
  assign busy = conv_busy;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Self-checking bench for seg7_scan_display: table vectors, multi-cycle corner
// sequences and random values checked against a decimal-arithmetic display model.
module tb_seg7_scan_display;

  localparam logic [6:0] P0 = 7'b1000000;
  localparam logic [6:0] P1 = 7'b1111001;
  localparam logic [6:0] P2 = 7'b0100100;
  localparam logic [6:0] P3 = 7'b0110000;
  localparam logic [6:0] P4 = 7'b0011001;
  localparam logic [6:0] P5 = 7'b0010010;
  localparam logic [6:0] P6 = 7'b0000010;
  localparam logic [6:0] P7 = 7'b1111000;
  localparam logic [6:0] P8 = 7'b0000000;
  localparam logic [6:0] P9 = 7'b0010000;

`ifdef SEG7_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  typedef struct {
    logic [14:0]     num;
    logic [4:0][6:0] segs;
    logic [4:0]      lz;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] number;
  logic [6:0]  seg;
  logic        dp;
  logic [4:0]  an;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [6:0] pat [10];
  vec_t tbl [6];

  seg7_scan_display #(.CLK_HZ(1000), .SCAN_HZ(100)) dut (
    .clk    (clk),
    .reset  (reset),
    .number (number),
    .seg    (seg),
    .dp     (dp),
    .an     (an),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_busy(input logic lvl, input int max, output int n);
    n = 0;
    while (busy !== lvl && n < max) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== lvl) begin
      errors++;
      $display("FAIL busy_wait: busy=%b after %0d cycles, expected %b", busy, n, lvl);
    end
  endtask

  // Decimal model of what each scan slot must show for value v
  function automatic void model(input int v, output logic [4:0][6:0] es, output logic [4:0] eb);
    int p;
    p = 1;
    for (int k = 0; k < 5; k++) begin
      es[k] = pat[(v / p) % 10];
      eb[k] = (k > 0) && (v < p);
      p = p * 10;
    end
  endfunction

  task automatic apply(input logic [14:0] v);
    int n;
    if (v !== number) begin
      number = v;
      wait_busy(1'b1, 4, n);
      wait_busy(1'b0, 40, n);
      @(negedge clk);
    end
  endtask

  // Every sample must be one legal slot of the expected display
  task automatic observe(input string name, input logic [4:0][6:0] es, input logic [4:0] eb,
                        input int cycles, input bit need_all);
    logic [4:0] seen;
    logic       ok;
    logic       bl;
    logic [4:0] ean;
    logic [6:0] esg;
    seen = '0;
    for (int c = 0; c < cycles; c++) begin
      ok = 1'b0;
      for (int k = 0; k < 5; k++) begin
        bl  = LZ && eb[k];
        ean = bl ? 5'h1F : ~(5'b00001 << k);
        esg = bl ? 7'h7F : es[k];
        if (an === ean && seg === esg && dp === 1'b1) begin
          ok = 1'b1;
          seen[k] = 1'b1;
        end
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL %s cycle %0d: an=%b seg=%b dp=%b, expected a slot of segs=%h blank=%b",
                 name, c, an, seg, dp, es, LZ ? eb : 5'b0);
      end
      @(negedge clk);
    end
    if (need_all) begin
      checks++;
      if (seen !== 5'h1F) begin
        errors++;
        $display("FAIL %s_coverage: slots seen %b expected 11111", name, seen);
      end
    end
  endtask

  initial begin
    logic [4:0][6:0] es;
    logic [4:0]      eb;
    int n, n1, n2;
    logic [14:0] v;

    pat = '{P0, P1, P2, P3, P4, P5, P6, P7, P8, P9};
    tbl[0] = '{15'd0,     {P0, P0, P0, P0, P0}, 5'b11110};
    tbl[1] = '{15'd7,     {P0, P0, P0, P0, P7}, 5'b11110};
    tbl[2] = '{15'd12345, {P1, P2, P3, P4, P5}, 5'b00000};
    tbl[3] = '{15'd32767, {P3, P2, P7, P6, P7}, 5'b00000};
    tbl[4] = '{15'd10000, {P1, P0, P0, P0, P0}, 5'b00000};
    tbl[5] = '{15'd305,   {P0, P0, P3, P0, P5}, 5'b11000};

    // Reset state and first conversion
    reset  = 1'b0;
    number = 15'd0;
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(an), 32'h1F);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_dp", 32'(dp), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    chk("busy_rise", 32'(busy), 32'h1);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("busy_high_len", 32'(n), 32'd16);
    @(negedge clk);
    observe("reset_zero", tbl[0].segs, tbl[0].lz, 55, 1'b1);

    // Table vectors
    for (int i = 0; i < 6; i++) begin
      apply(tbl[i].num);
      observe($sformatf("tbl%0d", i), tbl[i].segs, tbl[i].lz, 55, 1'b1);
    end

    // Change during conversion: 100 loads first, then 101 is picked up
    number = 15'd100;
    wait_busy(1'b1, 4, n);
    repeat (3) @(negedge clk);
    number = 15'd101;
    wait_busy(1'b0, 40, n);
    @(negedge clk);
    chk("busy_reassert", 32'(busy), 32'h1);
    model(100, es, eb);
    observe("hold_100", es, eb, 12, 1'b0);
    wait_busy(1'b0, 40, n);
    @(negedge clk);
    model(101, es, eb);
    observe("final_101", es, eb, 55, 1'b1);

    // Reset mid-conversion
    number = 15'd4321;
    wait_busy(1'b1, 4, n);
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_an", 32'(an), 32'h1F);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_seg", 32'(seg), 32'h7F);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wait_busy(1'b1, 4, n1);
    wait_busy(1'b0, 40, n2);
    chk("midrst_latency_ok", 32'((n1 + n2) <= 17), 32'h1);
    @(negedge clk);
    model(4321, es, eb);
    observe("after_midrst", es, eb, 55, 1'b1);

    // Random values against the decimal model
    for (int i = 0; i < 20; i++) begin
      v = 15'($urandom_range(32767));
      if (v == number) v = v ^ 15'd1;
      apply(v);
      model(int'(v), es, eb);
      observe($sformatf("rand_%0d", v), es, eb, 55, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
